// File: rtl/dmem_uart.sv
// dmem_uart: data-side memory subsystem for the single-cycle MIPS core.
// Holds a word-addressed data RAM, a free-running 32-bit cycle counter and a
// buffered 8N1 UART transmitter fed by a TX FIFO, all reached through sw/lw.
//
// Ports:
//   clk      - clock, all state updates on posedge
//   rst_n    - asynchronous active-low reset
//   addr     - byte address (core ALU result); addr[1:0] ignored
//   wdata    - store data
//   we       - store strobe (core memwrite)
//   rdata    - load data, combinational from addr and current state
//   uart_tx  - registered serial output, idles high
//
// Memory map:
//   addr[31:16]==0  RAM (word index addr[RAM_AW+1:2], upper bits alias)
//   0xFFFF_0000     TXDATA  write pushes wdata[7:0], reads 0
//   0xFFFF_0004     STATUS  {count[8+FIFO_AW:8], ovf, busy, empty, full}
//   0xFFFF_0008     CYCLES  read counter / write loads counter
module dmem_uart #(
    parameter int unsigned RAM_AW  = 8,
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned CLK_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        uart_tx
);

    localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
    localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W      = FIFO_AW + 1;
    localparam int unsigned BAUD_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0004;
    localparam logic [31:0] CYCLES_ADDR = 32'hFFFF_0008;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Address decode (byte offset bits are don't-care)
    logic              sel_ram;
    logic              sel_tx;
    logic              sel_stat;
    logic              sel_cyc;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr_bits;

    assign sel_ram          = (addr[31:16] == 16'h0000);
    assign sel_tx           = (addr[31:2] == TXDATA_ADDR[31:2]);
    assign sel_stat         = (addr[31:2] == STATUS_ADDR[31:2]);
    assign sel_cyc          = (addr[31:2] == CYCLES_ADDR[31:2]);
    assign ram_idx          = addr[RAM_AW+1:2];
    assign unused_addr_bits = ^addr[1:0];

    // Data RAM: synchronous write, asynchronous read, never reset
    logic [31:0] ram [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we && sel_ram) begin
            ram[ram_idx] <= wdata;
        end
    end

    // Free-running cycle counter; a store replaces this cycle's increment
    logic [31:0] cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= 32'd0;
        end else if (we && sel_cyc) begin
            cycles <= wdata;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    // TX FIFO bookkeeping
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               ovf_clr;
    state_t             state;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == CNT_W'(0));
    assign push_req   = we && sel_tx;
    // A full FIFO drops the push even if the FSM frees a slot this cycle
    assign push       = push_req && !fifo_full;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign ovf_clr    = we && sel_stat && wdata[3];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Sticky overflow; a same-cycle set beats the clear
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // UART transmit FSM, 8N1, LSB first
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              baud_end;

    assign baud_end = (baud_cnt == BAUD_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_mem[rd_ptr];
                        baud_cnt <= '0;
                        state    <= START;
                        uart_tx  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                        uart_tx  <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    uart_tx <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    // Load data mux; reads see pre-edge state (read-before-write)
    logic [31:0] status;

    always_comb begin
        status             = 32'h0000_0000;
        status[0]          = fifo_full;
        status[1]          = fifo_empty;
        status[2]          = (state != IDLE);
        status[3]          = overflow;
        status[8+FIFO_AW:8] = count;

        rdata = 32'h0000_0000;
        if (sel_ram) begin
            rdata = ram[ram_idx];
        end else if (sel_stat) begin
            rdata = status;
        end else if (sel_cyc) begin
            rdata = cycles;
        end
    end

endmodule

// File: tb/tb_dmem_uart.sv
// tb_dmem_uart: directed bench for dmem_uart with CLK_DIV=4. Expected UART
// bytes and their predicted first-start edges go into a scoreboard when the
// TXDATA store is driven; a line history indexed by clock edge is compared
// frame by frame at the end.
module tb_dmem_uart;

    localparam int unsigned CLK_DIV = 4;
    localparam int          PERIOD  = 10 * CLK_DIV + 1;
    localparam int          HIST_N  = 4096;

    localparam logic [31:0] A_TX = 32'hFFFF_0000;
    localparam logic [31:0] A_ST = 32'hFFFF_0004;
    localparam logic [31:0] A_CY = 32'hFFFF_0008;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        uart_tx;

    int n_assert;
    int n_fail;
    int cyc;

    logic hist [HIST_N];

    logic [7:0] sb_byte  [$];
    int         sb_start [$];

    dmem_uart #(
        .RAM_AW (8),
        .FIFO_AW(3),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .rdata  (rdata),
        .uart_tx(uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges so far; hist[k] = line after edge k
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < HIST_N) hist[cyc] = uart_tx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    // 41 samples: 4 start, 8x4 data LSB first, 4 stop, 1 idle/next-gap
    task automatic check_frame(input int start, input logic [7:0] b);
        logic [63:0] obs;
        logic [63:0] exp;
        obs = '0;
        exp = '0;
        for (int k = 0; k < PERIOD; k++) begin
            obs[k] = (start + k < HIST_N) ? hist[start + k] : 1'bx;
            if (k < 4)       exp[k] = 1'b0;
            else if (k < 36) exp[k] = b[(k - 4) / 4];
            else             exp[k] = 1'b1;
        end
        check($sformatf("frame_%02h_at_%0d", b, start), obs, exp);
    endtask

    initial begin
        int n_edge;
        int m_edge;
        int busy;
        logic [7:0] burst [9];
        logic [7:0] b;
        int         s;

        burst[0] = 8'h01; burst[1] = 8'h80; burst[2] = 8'hC3;
        burst[3] = 8'h3C; burst[4] = 8'hFF; burst[5] = 8'h00;
        burst[6] = 8'h96; burst[7] = 8'h69; burst[8] = 8'h77;

        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        we       = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;

        // Reset and first cycle after release
        repeat (3) tick();
        rst_n = 1'b1;
        addr  = A_CY;
        settle();
        check("cycles_after_reset", 64'(rdata), 64'h0);
        addr = A_ST;
        settle();
        check("status_after_reset", 64'(rdata), 64'h2);
        check("tx_after_reset", 64'(uart_tx), 64'h1);

        // Cycle counter load and wrap
        wr(A_CY, 32'hFFFF_FFFE);
        settle();
        check("cycles_load", 64'(rdata), 64'hFFFF_FFFE);
        tick();
        check("cycles_inc", 64'(rdata), 64'hFFFF_FFFF);
        tick();
        check("cycles_wrap", 64'(rdata), 64'h0);
        addr = 32'h8000_0000;
        settle();
        check("unmapped_read", 64'(rdata), 64'h0);

        // RAM write, read-before-write, aliasing
        wr(32'h0000_0010, 32'h1234_5678);
        addr  = 32'h0000_0010;
        wdata = 32'hDEAD_BEEF;
        we    = 1'b1;
        settle();
        check("ram_read_before_write", 64'(rdata), 64'h1234_5678);
        tick();
        we = 1'b0;
        settle();
        check("ram_read", 64'(rdata), 64'hDEAD_BEEF);
        addr = 32'h0000_0410;
        settle();
        check("ram_alias", 64'(rdata), 64'hDEAD_BEEF);
        addr = 32'h0001_0010;
        settle();
        check("non_ram_read", 64'(rdata), 64'h0);

        // Single byte, idle FSM: pops next edge, busy for 10*CLK_DIV cycles
        tick();
        wr(A_TX, 32'h0000_0055);
        n_edge = cyc;
        sb_byte.push_back(8'h55);
        sb_start.push_back(n_edge + 1);
        addr = A_ST;
        settle();
        check("status_after_push", 64'(rdata), 64'h100);
        check("tx_idle_before_pop", 64'(uart_tx), 64'h1);
        busy = 0;
        repeat (PERIOD) begin
            tick();
            busy += int'(rdata[2]);
        end
        check("busy_cycles", 64'(busy), 64'(10 * CLK_DIV));
        check("status_after_frame", 64'(rdata), 64'h2);

        // Burst of 9 stores while a frame is in flight: last one dropped
        tick();
        wr(A_TX, 32'h0000_00A5);
        m_edge = cyc;
        sb_byte.push_back(8'hA5);
        sb_start.push_back(m_edge + 1);
        tick();
        for (int j = 0; j < 9; j++) begin
            wr(A_TX, {24'h0, burst[j]});
            if (j < 8) begin
                sb_byte.push_back(burst[j]);
                sb_start.push_back(m_edge + 1 + PERIOD * (j + 1));
            end
        end
        addr = A_ST;
        settle();
        check("status_full_ovf", 64'(rdata), 64'h80D);
        wr(A_ST, 32'h0000_0008);
        settle();
        check("status_ovf_cleared", 64'(rdata), 64'h805);

        // Store lands on the edge where the FSM pops a full FIFO
        repeat ((m_edge + PERIOD) - cyc) tick();
        wr(A_TX, 32'h0000_00EE);
        check("full_pop_edge", 64'(cyc), 64'(m_edge + PERIOD + 1));
        addr = A_ST;
        settle();
        check("status_full_plus_pop", 64'(rdata), 64'h70C);

        // Drain every queued frame
        repeat ((m_edge + 1 + PERIOD * 9 + 2) - cyc) tick();
        check("status_drained", 64'(rdata), 64'hA);
        wr(A_ST, 32'h0000_0008);
        settle();
        check("status_drained_clr", 64'(rdata), 64'h2);

        // Async reset mid-frame
        wr(A_TX, 32'h0000_003C);
        repeat (10) tick();
        check("tx_mid_frame", 64'(uart_tx), 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("tx_async_reset", 64'(uart_tx), 64'h1);
        addr = A_ST;
        #1;
        check("status_in_reset", 64'(rdata), 64'h2);
        addr = 32'h0000_0010;
        #1;
        check("ram_kept_in_reset", 64'(rdata), 64'hDEAD_BEEF);
        rst_n = 1'b1;
        addr  = A_CY;
        #1;
        check("cycles_after_midreset", 64'(rdata), 64'h0);
        addr = A_ST;
        repeat (6) tick();
        check("tx_after_abandon", 64'(uart_tx), 64'h1);
        check("status_after_abandon", 64'(rdata), 64'h2);

        // Scoreboard: every accepted byte, in order, at its predicted slot
        check("sb_entries", 64'(sb_byte.size()), 64'd10);
        while (sb_byte.size() > 0) begin
            b = sb_byte.pop_front();
            s = sb_start.pop_front();
            check_frame(s, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
